mosquito_motion_controller: RTL and testbench

//   Owns position, direction and alive state of every mosquito enemy.

---
 rtl/mosquito_motion_controller.sv | 98 +++++++++
 tb/tb_mosquito_motion_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mosquito_motion_controller.sv
// mosquito_motion_controller: per-slot mosquito movement, kill handling, respawn and kill tally
module mosquito_motion_controller #(
   parameter int          MOSQUITO_COUNT = 4,
   parameter int          SCREEN_W       = 640,
   parameter int          SPRITE_SIZE    = 32,
   parameter int          Y_MAX          = 240,
   parameter int          SPEED          = 2,
   parameter int          X_SPACING      = 128,
   parameter int          RESPAWN_FRAMES = 60,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          frame_tick,
   input  logic [MOSQUITO_COUNT-1:0]     hit,
   output logic [10*MOSQUITO_COUNT-1:0]  mosquito_x_flat,
   output logic [10*MOSQUITO_COUNT-1:0]  mosquito_y_flat,
   output logic [MOSQUITO_COUNT-1:0]     mosquito_alive,
   output logic                          kill_pulse,
   output logic [7:0]                    kill_count
);
   localparam logic [9:0] X_LIMIT = 10'(SCREEN_W - SPRITE_SIZE);
   localparam logic [9:0] Y_LIMIT = 10'(Y_MAX - SPRITE_SIZE);
   localparam logic [9:0] SPD     = 10'(SPEED);
   typedef enum logic {ALIVE, DEAD} state_t;
   logic [15:0]               lfsr;
   logic [MOSQUITO_COUNT-1:0] kills;
   logic [2:0]                kill_n;
   logic [8:0]                kill_sum;
   for (genvar g = 0; g < MOSQUITO_COUNT; g++) begin : g_slot
      state_t      state;
      logic [9:0]  x, y, nx, ny;
      logic        dx, dy, ndx, ndy;
      logic [7:0]  cnt;
      logic [15:0] r;
      // spawn value is the shared LFSR rotated per slot so slots land apart
      assign r = 16'({lfsr, lfsr} >> (16 - 4 * g));
      // one frame of clamped bounce motion; limit test precedes add/sub so nothing wraps
      always_comb begin
         nx  = dx ? ((x + SPD >= X_LIMIT) ? X_LIMIT : x + SPD) : ((x <= SPD) ? '0 : x - SPD);
         ndx = dx ? (x + SPD < X_LIMIT) : (x <= SPD);
         ny  = dy ? ((y + SPD >= Y_LIMIT) ? Y_LIMIT : y + SPD) : ((y <= SPD) ? '0 : y - SPD);
         ndy = dy ? (y + SPD < Y_LIMIT) : (y <= SPD);
      end
      // ALIVE/DEAD slot FSM: hit beats frame_tick, dead slots count frames down to respawn
      always_ff @(posedge clk) begin
         if (rst) begin
            state <= ALIVE;
            x     <= 10'(SPRITE_SIZE + g * X_SPACING);
            y     <= 10'd32;
            dx    <= 1'b1;
            dy    <= 1'b1;
            cnt   <= '0;
         end else if (state == ALIVE) begin
            if (hit[g]) begin
               state <= DEAD;
               cnt   <= 8'(RESPAWN_FRAMES);
            end else if (frame_tick) begin
               x  <= nx;
               y  <= ny;
               dx <= ndx;
               dy <= ndy;
            end
         end else if (frame_tick) begin
            if (cnt > 8'd1) cnt <= cnt - 8'd1;
            else begin
               state <= ALIVE;
               x     <= {1'b0, r[8:0]};
               y     <= {4'b0, r[15:10]};
               dx    <= r[9];
               dy    <= 1'b1;
            end
         end
      end
      assign mosquito_x_flat[g*10 +: 10] = x;
      assign mosquito_y_flat[g*10 +: 10] = y;
      assign mosquito_alive[g]           = (state == ALIVE);
   end
   // only live slots can be killed; count them for the score
   always_comb begin
      kills  = hit & mosquito_alive;
      kill_n = '0;
      for (int i = 0; i < MOSQUITO_COUNT; i++) kill_n = kill_n + 3'(kills[i]);
      kill_sum = {1'b0, kill_count} + 9'(kill_n);
   end
   // spawn LFSR (taps 16,14,13,11) and saturating kill tally
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr       <= LFSR_SEED;
         kill_pulse <= 1'b0;
         kill_count <= '0;
      end else begin
         lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         kill_pulse <= |kills;
         kill_count <= kill_sum[8] ? 8'hFF : kill_sum[7:0];
      end
   end
endmodule

// File: tb/tb_mosquito_motion_controller.sv
// tb_mosquito_motion_controller: directed self-checking bench for the mosquito controller
module tb_mosquito_motion_controller;
   logic        clk = 0;
   logic        rst = 1;
   logic        frame_tick = 0;
   logic [3:0]  hit = 0;
   logic [39:0] x_flat, y_flat;
   logic [3:0]  alive;
   logic        kill_pulse;
   logic [7:0]  kill_count;
   logic [15:0] lfsr_m;
   logic [9:0]  ex, ey, px, py;
   logic [15:0] rr;
   int          checks = 0;
   int          errors = 0;
   int          exp_kc;

   mosquito_motion_controller dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .hit(hit),
      .mosquito_x_flat(x_flat), .mosquito_y_flat(y_flat),
      .mosquito_alive(alive), .kill_pulse(kill_pulse), .kill_count(kill_count)
   );

   always #5 clk = ~clk;

   // reference spawn LFSR, shift-left Fibonacci with taps 16,14,13,11
   always @(posedge clk) lfsr_m <= rst ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

   function automatic logic [9:0] sx(int i);
      return x_flat[i*10 +: 10];
   endfunction

   function automatic logic [9:0] sy(int i);
      return y_flat[i*10 +: 10];
   endfunction

   task automatic cyc(input logic ft, input logic [3:0] h);
      frame_tick = ft;
      hit = h;
      @(negedge clk);
      frame_tick = 0;
      hit = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      frame_tick = 1;
      hit = 4'hF;
      @(negedge clk);
      rst = 0;
      frame_tick = 0;
      hit = 0;
      checks++; if (x_flat !== {10'd416, 10'd288, 10'd160, 10'd32}) begin errors++; $display("FAIL reset_x: got %h expected %h", x_flat, {10'd416, 10'd288, 10'd160, 10'd32}); end
      checks++; if (y_flat !== {4{10'd32}}) begin errors++; $display("FAIL reset_y: got %h expected %h", y_flat, {4{10'd32}}); end
      checks++; if (alive !== 4'b1111) begin errors++; $display("FAIL reset_alive: got %b expected 1111", alive); end
      checks++; if (kill_count !== 8'd0) begin errors++; $display("FAIL reset_kill_count: got %0d expected 0", kill_count); end
      checks++; if (kill_pulse !== 1'b0) begin errors++; $display("FAIL reset_kill_pulse: got %b expected 0", kill_pulse); end
   endtask

   task automatic test_move();
      do_reset();
      cyc(1, 0);
      checks++; if (sx(0) !== 10'd34) begin errors++; $display("FAIL move_x0: got %0d expected 34", sx(0)); end
      checks++; if (sy(0) !== 10'd34) begin errors++; $display("FAIL move_y0: got %0d expected 34", sy(0)); end
      checks++; if (sx(3) !== 10'd418) begin errors++; $display("FAIL move_x3: got %0d expected 418", sx(3)); end
      repeat (3) cyc(0, 0);
      checks++; if (sx(0) !== 10'd34 || sy(0) !== 10'd34) begin errors++; $display("FAIL move_hold: got %0d,%0d expected 34,34", sx(0), sy(0)); end
   endtask

   task automatic test_bounce();
      do_reset();
      for (int t = 1; t <= 289; t++) begin
         cyc(1, 0);
         if (t == 88) begin checks++; if (sy(0) !== 10'd208) begin errors++; $display("FAIL bounce_y88: got %0d expected 208", sy(0)); end end
         if (t == 89) begin checks++; if (sy(0) !== 10'd206) begin errors++; $display("FAIL bounce_y89: got %0d expected 206", sy(0)); end end
         if (t == 192) begin checks++; if (sy(0) !== 10'd0) begin errors++; $display("FAIL bounce_y192: got %0d expected 0", sy(0)); end end
         if (t == 193) begin checks++; if (sy(0) !== 10'd2) begin errors++; $display("FAIL bounce_y193: got %0d expected 2", sy(0)); end end
         if (t == 288) begin checks++; if (sx(0) !== 10'd608) begin errors++; $display("FAIL bounce_x288: got %0d expected 608", sx(0)); end end
         if (t == 289) begin checks++; if (sx(0) !== 10'd606) begin errors++; $display("FAIL bounce_x289: got %0d expected 606", sx(0)); end end
      end
   endtask

   task automatic test_hit();
      do_reset();
      cyc(1, 4'b0010);
      checks++; if (alive !== 4'b1101) begin errors++; $display("FAIL hit_alive: got %b expected 1101", alive); end
      checks++; if (kill_pulse !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %b expected 1", kill_pulse); end
      checks++; if (kill_count !== 8'd1) begin errors++; $display("FAIL hit_count: got %0d expected 1", kill_count); end
      checks++; if (sx(1) !== 10'd160 || sy(1) !== 10'd32) begin errors++; $display("FAIL hit_hold: got %0d,%0d expected 160,32", sx(1), sy(1)); end
      checks++; if (sx(0) !== 10'd34) begin errors++; $display("FAIL hit_other_moves: got %0d expected 34", sx(0)); end
      cyc(0, 0);
      checks++; if (kill_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse_one_cycle: got %b expected 0", kill_pulse); end
      cyc(0, 4'b0010);
      checks++; if (kill_count !== 8'd1 || kill_pulse !== 1'b0) begin errors++; $display("FAIL hit_dead_ignored: got %0d/%b expected 1/0", kill_count, kill_pulse); end
   endtask

   task automatic test_respawn();
      repeat (59) cyc(1, 0);
      checks++; if (alive[1] !== 1'b0) begin errors++; $display("FAIL respawn_early: got %b expected 0", alive[1]); end
      rr = {lfsr_m[11:0], lfsr_m[15:12]};
      ex = {1'b0, rr[8:0]};
      ey = {4'b0, rr[15:10]};
      cyc(1, 0);
      checks++; if (alive !== 4'b1111) begin errors++; $display("FAIL respawn_alive: got %b expected 1111", alive); end
      checks++; if (sx(1) !== ex || sy(1) !== ey) begin errors++; $display("FAIL respawn_pos: got %0d,%0d expected %0d,%0d", sx(1), sy(1), ex, ey); end
      checks++; if (sx(1) > 10'd511 || sy(1) > 10'd63) begin errors++; $display("FAIL respawn_range: got %0d,%0d expected <=511,<=63", sx(1), sy(1)); end
      px = sx(1);
      py = sy(1);
      cyc(1, 0);
      ex = rr[9] ? px + 10'd2 : (px <= 10'd2 ? 10'd0 : px - 10'd2);
      checks++; if (sx(1) !== ex || sy(1) !== py + 10'd2) begin errors++; $display("FAIL respawn_dir: got %0d,%0d expected %0d,%0d", sx(1), sy(1), ex, py + 10'd2); end
   endtask

   task automatic test_repeat();
      do_reset();
      cyc(1, 4'b0010);
      cyc(0, 0);
      cyc(0, 4'b0010);
      repeat (60) cyc(1, 0);
      checks++; if (sx(1) !== px || sy(1) !== py) begin errors++; $display("FAIL repeat_pos: got %0d,%0d expected %0d,%0d", sx(1), sy(1), px, py); end
   endtask

   task automatic test_multi_kill();
      do_reset();
      exp_kc = 0;
      for (int k = 0; k < 63; k++) begin
         cyc(0, 4'hF);
         exp_kc += 4;
         if (k == 0) begin
            checks++; if (kill_count !== 8'd4 || alive !== 4'b0000) begin errors++; $display("FAIL multi_first: got %0d/%b expected 4/0000", kill_count, alive); end
         end
         repeat (60) cyc(1, 0);
      end
      checks++; if (kill_count !== 8'(exp_kc) || alive !== 4'hF) begin errors++; $display("FAIL multi_252: got %0d/%b expected %0d/1111", kill_count, alive, exp_kc); end
      cyc(0, 4'b0011);
      checks++; if (kill_count !== 8'd254) begin errors++; $display("FAIL multi_254: got %0d expected 254", kill_count); end
      repeat (60) cyc(1, 0);
      cyc(0, 4'hF);
      checks++; if (kill_count !== 8'd255 || kill_pulse !== 1'b1) begin errors++; $display("FAIL multi_saturate: got %0d/%b expected 255/1", kill_count, kill_pulse); end
      repeat (60) cyc(1, 0);
      cyc(0, 4'b0100);
      checks++; if (kill_count !== 8'd255) begin errors++; $display("FAIL multi_hold_255: got %0d expected 255", kill_count); end
      repeat (5) cyc(1, 0);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_move();
      test_bounce();
      test_hit();
      test_respawn();
      test_repeat();
      test_multi_kill();
      test_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
